matrix_scan_capture: RTL and testbench
======================================

// Module: matrix_scan_capture
// PURPOSE
//  Receive side of the 16x16 LED matrix scan interface. Samples Array_row/Array_col,
//  rebuilds one full frame per ascending scan, and publishes it double-buffered.
//  Provides a coordinate read port, lit/diff pixel counts and scan-health flags.
//  Used for on-board display self-check and as the bench monitor for the matrix driver.
// PARAMETERS
//  SYNC_STAGES     2      input flops on Array_row/Array_col (>=1)
//  SETTLE_CYCLES   4      consecutive identical samples before a row is captured (>=1)
//  TIMEOUT_CYCLES  65535  cycles with no capture before scan_lost is set
//  ROW_ACTIVE      1      level of the selected row line (1=high, 0=low)
//  COL_ACTIVE      0      level of a lit column line (1=high, 0=low)
// PORTS
//  Clk          in   1   scan-domain clock
//  rst          in   1   synchronous, active-high reset
//  Array_row    in   16  row select lines from the matrix driver
//  Array_col    in   16  column data lines from the matrix driver
//  rd_coord     in   8   read address {y[7:4], x[3:0]}, same format as snake/apple coords
//  rd_pixel     out  1   pixel at rd_coord, front buffer, 1-cycle latency
//  rd_row_bits  out  16  whole front-buffer row y=rd_coord[7:4], 1-cycle latency
//  frame_valid  out  1   1-cycle pulse on every frame commit
//  frame_count  out  16  committed frames, wraps 0xFFFF->0
//  lit_count    out  9   lit pixels in the front buffer (0..256)
//  diff_count   out  9   pixels changed vs the previous front buffer (see CONFIGURATION)
//  scan_lost    out  1   sticky; set on timeout, cleared on the next commit
//  err_seq      out  1   1-cycle pulse: captured row index != expected index
//  err_onehot   out  1   1-cycle pulse: settled row is multi-hot
// BEHAVIOUR
//  - Reset: all outputs 0; shadow/front buffers cleared; FSM=WAIT_START; counters 0.
//  - Normalise: r = ROW_ACTIVE ? row : ~row; c = COL_ACTIVE ? col : ~col. Pixel(y,x)=c[x] while r=1<<y.
//  - Settle: after sync, a counter increments while {r,c} equals the previous sample and
//    resets to 0 on any change. At count == SETTLE_CYCLES: if r is one-hot, it is a capture
//    event (at most one per assertion; the next capture needs a change in r, including to 0).
//    r==0 is ignored; multi-hot raises err_onehot and is otherwise ignored.
//  - FSM WAIT_START: capture y==0 -> write shadow[0], exp=1, go CAPTURE; any other y is
//    dropped silently.
//  - FSM CAPTURE: y==exp -> write shadow[y], exp++. y!=exp -> err_seq pulse; if y==0, restart
//    (shadow[0] written, exp=1); else go WAIT_START.
//  - Capture of y==15 in CAPTURE commits: on the next edge front<=shadow, frame_valid=1,
//    frame_count++, lit_count<=running sum, scan_lost<=0, FSM->WAIT_START.
//  - Running lit sum: cleared on row-0 capture, += popcount16(c) on each capture; no overflow (max 256).
//  - Latency from pins of row 15 to frame_valid: SYNC_STAGES+SETTLE_CYCLES+1 cycles.
//  - Timeout: a counter cleared on every capture event, saturating. Reaching TIMEOUT_CYCLES
//    sets scan_lost and forces WAIT_START; the front buffer is kept.
//  - Read port: registered from the front buffer. A read issued in the commit cycle returns
//    pre-commit data; the new frame is visible from the following read.
//  - rst mid-frame: partial shadow discarded; no frame_valid.
// CONFIGURATION
//  MATRIX_DIFF_EN defined: each capture adds popcount16(c ^ front[y]) to a running diff sum,
//    which is published to diff_count at commit.
//  MATRIX_DIFF_EN undefined: no diff logic; diff_count is tied to 0.
// STRUCTURE
//  Package snake_matrix_pkg: MATRIX_N=16, coord_t (8-bit {y,x}), popcount16(), coord_x/coord_y().
//  Sub-module matrix_row_sampler: sync stages, normalisation, settle counter, one-hot check;
//    emits cap_valid/cap_y/cap_bits/onehot_err. The FSM, buffers and counters live in the top.
// TESTING
//  1 Clean scan rows 0..15, col bit x lit iff x==y -> one frame_valid, lit_count=16,
//    rd_coord=8'h55 -> rd_pixel=1, rd_coord=8'h56 -> rd_pixel=0.
//  2 Scan 0..5, then row 7 -> err_seq pulse, no commit; then a clean 0..15 -> frame_count=1.
//  3 Row lines 0x0003 held SETTLE_CYCLES -> err_onehot pulse, exp unchanged; glitch shorter
//    than SETTLE_CYCLES -> no capture.
//  4 Stop scanning for TIMEOUT_CYCLES -> scan_lost=1, rd data unchanged; next full scan
//    -> scan_lost=0, frame_valid pulse.
//  5 Two frames, second with 3 pixels toggled -> MATRIX_DIFF_EN: diff_count=3; undefined: 0.
//  6 Assert rst while row 8 is settling -> all outputs 0; a full scan afterwards -> frame_count=1.

Source files
------------

// File: rtl/snake_matrix_pkg.sv
// Shared types and helpers for the LED matrix scan capture block.
package snake_matrix_pkg;

    localparam int unsigned MATRIX_N = 16;
    localparam int unsigned Y_W      = 4;
    localparam int unsigned COORD_W  = 8;
    localparam int unsigned POP_W    = 5;
    localparam int unsigned COUNT_W  = 9;
    localparam int unsigned FRAME_W  = 16;

    typedef logic [COORD_W-1:0]  coord_t;
    typedef logic [MATRIX_N-1:0] row_t;

    typedef enum logic {
        WAIT_START = 1'b0,
        CAPTURE    = 1'b1
    } scan_state_e;

    function automatic logic [POP_W-1:0] popcount16(input row_t v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(MATRIX_N); i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [Y_W-1:0] coord_x(input coord_t c);
        return c[Y_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] coord_y(input coord_t c);
        return c[COORD_W-1:Y_W];
    endfunction

endpackage

// File: rtl/matrix_scan_capture_if.sv
// Pin, read-port and status bundle of the matrix scan capture block.
interface matrix_scan_capture_if;
    import snake_matrix_pkg::*;

    row_t                 Array_row;
    row_t                 Array_col;
    coord_t               rd_coord;
    logic                 rd_pixel;
    row_t                 rd_row_bits;
    logic                 frame_valid;
    logic [FRAME_W-1:0]   frame_count;
    logic [COUNT_W-1:0]   lit_count;
    logic [COUNT_W-1:0]   diff_count;
    logic                 scan_lost;
    logic                 err_seq;
    logic                 err_onehot;

    modport master (
        output Array_row, Array_col, rd_coord,
        input  rd_pixel, rd_row_bits, frame_valid, frame_count,
               lit_count, diff_count, scan_lost, err_seq, err_onehot
    );

    modport slave (
        input  Array_row, Array_col, rd_coord,
        output rd_pixel, rd_row_bits, frame_valid, frame_count,
               lit_count, diff_count, scan_lost, err_seq, err_onehot
    );

endinterface

// File: rtl/matrix_row_sampler.sv
// Synchronises the row/column lines, waits for them to settle and emits one
// capture per stable one-hot row selection.
module matrix_row_sampler
    import snake_matrix_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned ROW_ACTIVE    = 1,
    parameter int unsigned COL_ACTIVE    = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  row_t            raw_row,
    input  row_t            raw_col,
    output logic            cap_valid,
    output logic [Y_W-1:0]  cap_y,
    output row_t            cap_bits,
    output logic            onehot_err
);

    localparam int unsigned LAST  = SYNC_STAGES - 1;
    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    logic [SYNC_STAGES-1:0][MATRIX_N-1:0] row_sync;
    logic [SYNC_STAGES-1:0][MATRIX_N-1:0] col_sync;
    row_t             r, c, prev_r, prev_c;
    logic [CNT_W-1:0] cnt;
    logic             armed, same, settled, onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_sync <= '0;
            col_sync <= '0;
        end else begin
            row_sync[0] <= raw_row;
            col_sync[0] <= raw_col;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                row_sync[i] <= row_sync[i-1];
                col_sync[i] <= col_sync[i-1];
            end
        end
    end

    assign r = (ROW_ACTIVE != 0) ? row_sync[LAST] : ~row_sync[LAST];
    assign c = (COL_ACTIVE != 0) ? col_sync[LAST] : ~col_sync[LAST];

    // cnt+1 is the number of consecutive identical samples including the current one
    assign same    = (r == prev_r) && (c == prev_c);
    assign settled = same && (cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign onehot  = (r != '0) && ((r & (r - row_t'(1))) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r <= '0;
            prev_c <= '0;
            cnt    <= '0;
            armed  <= 1'b1;
        end else begin
            prev_r <= r;
            prev_c <= c;
            if (!same) begin
                cnt <= '0;
            end else if (cnt != CNT_W'(SETTLE_CYCLES)) begin
                cnt <= cnt + CNT_W'(1);
            end
            // a row may only be captured again after the row lines have moved
            if (r != prev_r) begin
                armed <= 1'b1;
            end else if (cap_valid) begin
                armed <= 1'b0;
            end
        end
    end

    assign cap_valid  = settled && onehot && armed;
    assign onehot_err = settled && (r != '0) && !onehot;
    assign cap_bits   = c;

    always_comb begin
        cap_y = '0;
        for (int i = 0; i < int'(MATRIX_N); i++) begin
            if (r[i]) begin
                cap_y = Y_W'(i);
            end
        end
    end

endmodule

// File: rtl/matrix_scan_capture.sv
// Rebuilds 16x16 frames from the matrix scan lines and publishes them double-buffered.
// Optional feature: define MATRIX_DIFF_EN to count pixels changed between frames.
module matrix_scan_capture
    import snake_matrix_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned ROW_ACTIVE     = 1,
    parameter int unsigned COL_ACTIVE     = 0
) (
    input  logic                  Clk,
    input  logic                  rst,
    matrix_scan_capture_if.slave  bus
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic                               cap_valid, onehot_err;
    logic [Y_W-1:0]                     cap_y;
    row_t                               cap_bits;
    logic [POP_W-1:0]                   row_pop;
    scan_state_e                        state, state_next;
    logic [Y_W-1:0]                     exp_y, exp_next;
    logic                               wr_row, start_frame, commit, seq_err, timeout_hit;
    logic [MATRIX_N-1:0][MATRIX_N-1:0]  shadow, front;
    logic [COUNT_W-1:0]                 lit_sum;
    logic [TO_W-1:0]                    to_cnt;

    matrix_row_sampler #(
        .SYNC_STAGES   (SYNC_STAGES),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .ROW_ACTIVE    (ROW_ACTIVE),
        .COL_ACTIVE    (COL_ACTIVE)
    ) u_sampler (
        .clk        (Clk),
        .rst        (rst),
        .raw_row    (bus.Array_row),
        .raw_col    (bus.Array_col),
        .cap_valid  (cap_valid),
        .cap_y      (cap_y),
        .cap_bits   (cap_bits),
        .onehot_err (onehot_err)
    );

    assign row_pop     = popcount16(cap_bits);
    assign timeout_hit = !cap_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Row sequencing: frames must arrive as an unbroken ascending 0..15 scan
    always_comb begin
        state_next  = state;
        exp_next    = exp_y;
        wr_row      = 1'b0;
        start_frame = 1'b0;
        commit      = 1'b0;
        seq_err     = 1'b0;
        case (state)
            WAIT_START: begin
                if (cap_valid && cap_y == '0) begin
                    wr_row      = 1'b1;
                    start_frame = 1'b1;
                    exp_next    = Y_W'(1);
                    state_next  = CAPTURE;
                end
            end
            CAPTURE: begin
                if (cap_valid) begin
                    if (cap_y == exp_y) begin
                        wr_row   = 1'b1;
                        exp_next = exp_y + Y_W'(1);
                        if (cap_y == Y_W'(MATRIX_N - 1)) begin
                            commit     = 1'b1;
                            state_next = WAIT_START;
                        end
                    end else begin
                        seq_err = 1'b1;
                        if (cap_y == '0) begin
                            wr_row      = 1'b1;
                            start_frame = 1'b1;
                            exp_next    = Y_W'(1);
                        end else begin
                            state_next = WAIT_START;
                        end
                    end
                end
            end
            default: state_next = WAIT_START;
        endcase
        if (timeout_hit) begin
            state_next = WAIT_START;
        end
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            state           <= WAIT_START;
            exp_y           <= '0;
            shadow          <= '0;
            front           <= '0;
            lit_sum         <= '0;
            to_cnt          <= '0;
            bus.frame_valid <= 1'b0;
            bus.frame_count <= '0;
            bus.lit_count   <= '0;
            bus.scan_lost   <= 1'b0;
            bus.err_seq     <= 1'b0;
            bus.err_onehot  <= 1'b0;
            bus.rd_pixel    <= 1'b0;
            bus.rd_row_bits <= '0;
        end else begin
            state <= state_next;
            exp_y <= exp_next;
            if (wr_row) begin
                shadow[cap_y] <= cap_bits;
            end
            if (start_frame) begin
                lit_sum <= COUNT_W'(row_pop);
            end else if (wr_row) begin
                lit_sum <= lit_sum + COUNT_W'(row_pop);
            end
            if (cap_valid) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            // Row 15 goes straight into the front buffer so commit costs no extra cycle
            bus.frame_valid <= commit;
            if (commit) begin
                front                      <= shadow;
                front[Y_W'(MATRIX_N - 1)]  <= cap_bits;
                bus.frame_count            <= bus.frame_count + FRAME_W'(1);
                bus.lit_count              <= lit_sum + COUNT_W'(row_pop);
            end
            if (commit) begin
                bus.scan_lost <= 1'b0;
            end else if (timeout_hit) begin
                bus.scan_lost <= 1'b1;
            end
            bus.err_seq     <= seq_err;
            bus.err_onehot  <= onehot_err;
            bus.rd_row_bits <= front[coord_y(bus.rd_coord)];
            bus.rd_pixel    <= front[coord_y(bus.rd_coord)][coord_x(bus.rd_coord)];
        end
    end

`ifdef MATRIX_DIFF_EN
    logic [POP_W-1:0]   row_diff;
    logic [COUNT_W-1:0] diff_sum;

    assign row_diff = popcount16(cap_bits ^ front[cap_y]);

    // Compared against the front buffer as it stands when each row lands
    always_ff @(posedge Clk) begin
        if (rst) begin
            diff_sum       <= '0;
            bus.diff_count <= '0;
        end else begin
            if (start_frame) begin
                diff_sum <= COUNT_W'(row_diff);
            end else if (wr_row) begin
                diff_sum <= diff_sum + COUNT_W'(row_diff);
            end
            if (commit) begin
                bus.diff_count <= diff_sum + COUNT_W'(row_diff);
            end
        end
    end
`else
    assign bus.diff_count = '0;
`endif

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Scoreboard bench for matrix_scan_capture: expected pulses queued at stimulus time, checked by a monitor.
module tb_matrix_scan_capture;
    import snake_matrix_pkg::*;

    localparam int unsigned SYNC    = 2;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 300;
    localparam int          LAT     = 7;
    localparam int          HOLD    = 8;

    localparam int EV_FRAME  = 0;
    localparam int EV_SEQ    = 1;
    localparam int EV_ONEHOT = 2;

    typedef struct {
        int kind;
        int fc;
        int lit;
        int diff;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   t15;
    int   n_pass;
    int   n_total;
    exp_t sb[$];
    row_t img [16];

    matrix_scan_capture_if bus ();

    matrix_scan_capture #(
        .SYNC_STAGES    (SYNC),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .ROW_ACTIVE     (1),
        .COL_ACTIVE     (0)
    ) dut (
        .Clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    function automatic exp_t ev(input int kind, input int fc, input int lit, input int diff);
        exp_t e;
        e.kind = kind;
        e.fc   = fc;
        e.lit  = lit;
        e.diff = diff;
        return e;
    endfunction

    function automatic int dsel(input int d);
`ifdef MATRIX_DIFF_EN
        return d;
`else
        return (d == d) ? 0 : 0;
`endif
    endfunction

    // Monitor: every output pulse consumes one queued expectation
    always @(negedge clk) begin
        if (!rst && (bus.frame_valid || bus.err_seq || bus.err_onehot)) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pulse: fv=%0b seq=%0b oh=%0b with empty queue (cycle %0d)",
                         bus.frame_valid, bus.err_seq, bus.err_onehot, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.frame_valid) begin
                    check("frame_kind", 32'(EV_FRAME), 32'(e.kind));
                    check("frame_count", 32'(bus.frame_count), 32'(e.fc));
                    check("lit_count", 32'(bus.lit_count), 32'(e.lit));
                    check("diff_count", 32'(bus.diff_count), 32'(e.diff));
                    check("commit_latency", 32'(cyc - t15), 32'(LAT));
                end else if (bus.err_seq) begin
                    check("err_seq_kind", 32'(EV_SEQ), 32'(e.kind));
                end else begin
                    check("err_onehot_kind", 32'(EV_ONEHOT), 32'(e.kind));
                end
            end
        end
    end

    // Called at a negedge; leaves the lines for `hold` cycles
    task automatic drive(input row_t row, input row_t pix, input int hold);
        bus.Array_row = row;
        bus.Array_col = ~pix;
        if (row == 16'h8000) t15 = cyc;
        repeat (hold) @(negedge clk);
    endtask

    task automatic scan_rows(input int first, input int last);
        for (int y = first; y <= last; y++) begin
            drive(row_t'(1) << y, img[y], HOLD);
        end
    endtask

    task automatic set_diag();
        for (int y = 0; y < 16; y++) img[y] = row_t'(1) << y;
    endtask

    task automatic read_pix(input string name, input coord_t a, input logic exp);
        bus.rd_coord = a;
        @(negedge clk);
        check(name, 32'(bus.rd_pixel), 32'(exp));
    endtask

    task automatic read_row(input string name, input coord_t a, input row_t exp);
        bus.rd_coord = a;
        @(negedge clk);
        check(name, 32'(bus.rd_row_bits), 32'(exp));
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_frame_count"}, 32'(bus.frame_count), 32'd0);
        check({tag, "_lit_count"},   32'(bus.lit_count),   32'd0);
        check({tag, "_diff_count"},  32'(bus.diff_count),  32'd0);
        check({tag, "_scan_lost"},   32'(bus.scan_lost),   32'd0);
        check({tag, "_frame_valid"}, 32'(bus.frame_valid), 32'd0);
        check({tag, "_rd_row_bits"}, 32'(bus.rd_row_bits), 32'd0);
        check({tag, "_rd_pixel"},    32'(bus.rd_pixel),    32'd0);
    endtask

    initial begin
        cyc     = 0;
        t15     = 0;
        n_pass  = 0;
        n_total = 0;
        rst           = 1'b1;
        bus.Array_row = '0;
        bus.Array_col = 16'hFFFF;
        bus.rd_coord  = '0;
        repeat (3) @(negedge clk);
        check_zero_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // Clean diagonal frame
        set_diag();
        sb.push_back(ev(EV_FRAME, 1, 16, dsel(16)));
        scan_rows(0, 15);
        drive('0, '0, 12);
        read_pix("diag_pix_55", 8'h55, 1'b1);
        read_pix("diag_pix_56", 8'h56, 1'b0);
        read_row("diag_row_3", 8'h30, 16'h0008);

        // Sequence break at row 7, then a clean frame
        scan_rows(0, 5);
        sb.push_back(ev(EV_SEQ, 0, 0, 0));
        scan_rows(7, 7);
        sb.push_back(ev(EV_FRAME, 2, 16, dsel(0)));
        scan_rows(0, 15);
        drive('0, '0, 12);
        check("after_seq_frame_count", 32'(bus.frame_count), 32'd2);

        // Multi-hot row and a short glitch inside an otherwise clean frame
        scan_rows(0, 3);
        sb.push_back(ev(EV_ONEHOT, 0, 0, 0));
        drive(16'h0003, 16'h0003, HOLD);
        scan_rows(4, 4);
        drive(16'h0200, 16'hFFFF, 2);
        sb.push_back(ev(EV_FRAME, 3, 16, dsel(0)));
        scan_rows(5, 15);
        drive('0, '0, 12);

        // Scan stops: scan_lost rises, published frame untouched
        check("lost_before_timeout", 32'(bus.scan_lost), 32'd0);
        drive('0, '0, TIMEOUT + 20);
        check("lost_after_timeout", 32'(bus.scan_lost), 32'd1);
        read_pix("lost_pix_55", 8'h55, 1'b1);
        read_row("lost_row_5", 8'h50, 16'h0020);

        // Recovery frame with (2,3) set, (9,9) cleared and (15,0) set
        img[2]  = 16'h000C;
        img[9]  = 16'h0000;
        img[15] = 16'h8001;
        sb.push_back(ev(EV_FRAME, 4, 17, dsel(3)));
        scan_rows(0, 15);
        drive('0, '0, 12);
        check("lost_cleared", 32'(bus.scan_lost), 32'd0);
        read_pix("new_pix_23", 8'h23, 1'b1);
        read_pix("new_pix_99", 8'h99, 1'b0);
        read_row("new_row_15", 8'hF0, 16'h8001);

        // Reset while row 8 is settling discards the partial frame
        set_diag();
        scan_rows(0, 7);
        drive(16'h0100, img[8], 3);
        rst = 1'b1;
        bus.Array_row = '0;
        bus.Array_col = 16'hFFFF;
        repeat (2) @(negedge clk);
        check_zero_state("midrst");
        rst = 1'b0;
        @(negedge clk);
        sb.push_back(ev(EV_FRAME, 1, 16, dsel(16)));
        scan_rows(0, 15);
        drive('0, '0, 12);
        read_pix("midrst_pix_55", 8'h55, 1'b1);

        check("queue_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
